// File: rtl/conv_32_8.sv
// 32-bit to 8-bit serializer: accepts one word per four clk_4f cycles and emits
// it MSB first; IDLE_SYM fills the link whenever no payload byte is sent.
module conv_32_8 #(
  parameter logic [7:0] IDLE_SYM = 8'hBC
) (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic        active,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [7:0]  data_out,
  output logic        valid_out
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [1:0]  cnt_r;
  logic [1:0]  cnt_s;
  logic [31:0] hold_r;
  logic [31:0] hold_s;
  logic [7:0]  data_s;
  logic        valid_s;
  logic        accept_s;

  // Ready only in IDLE; reset_L is folded in so ready is low throughout reset.
  assign ready_out = reset_L & active & (state_r == IDLE);
  assign accept_s  = valid_in & ready_out;

  // Next-state and next-output logic; the accept edge already emits the MSB.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    hold_s  = hold_r;
    data_s  = IDLE_SYM;
    valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          hold_s  = data_in;
          data_s  = data_in[31:24];
          valid_s = 1'b1;
          cnt_s   = 2'd1;
          state_s = SEND;
        end else begin
          data_s  = IDLE_SYM;
          valid_s = 1'b0;
        end
      end
      SEND: begin
        // cnt wraps 3 -> 0 on the final byte, matching the return to IDLE.
        cnt_s   = cnt_r + 2'd1;
        valid_s = 1'b1;
        case (cnt_r)
          2'd1:    data_s = hold_r[23:16];
          2'd2:    data_s = hold_r[15:8];
          2'd3: begin
            data_s  = hold_r[7:0];
            state_s = IDLE;
          end
          default: begin
            data_s  = IDLE_SYM;
            valid_s = 1'b0;
            cnt_s   = 2'd0;
            state_s = IDLE;
          end
        endcase
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
        data_s  = IDLE_SYM;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any word in flight.
  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      state_r   <= IDLE;
      cnt_r     <= 2'd0;
      hold_r    <= 32'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      hold_r    <= hold_s;
      data_out  <= data_s;
      valid_out <= valid_s;
    end
  end

endmodule

// File: tb/tb_conv_32_8.sv
// Directed self-checking bench for conv_32_8: reset, single word, back-to-back,
// active drop, reset mid-word and stalled upstream word.
module tb_conv_32_8;

  logic        clk_4f = 1'b0;
  logic        reset_L;
  logic        active;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [7:0]  data_out;
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_4f = ~clk_4f;

  conv_32_8 #(.IDLE_SYM(8'hBC)) dut (
    .clk_4f    (clk_4f),
    .reset_L   (reset_L),
    .active    (active),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset();
    reset_L  = 1'b0;
    active   = 1'b1;
    valid_in = 1'b1;
    data_in  = 32'hFFFFFFFF;
    #1;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready_out=%b expected 0", ready_out);
    end
    tick();
    tick();
    checks++;
    if (data_out !== 8'h00 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: data_out=%h valid_out=%b expected 00/0", data_out, valid_out);
    end
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_hold: ready_out=%b expected 0", ready_out);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_b [4];
    exp_b = '{8'hAB, 8'hCD, 8'h00, 8'h01};
    reset_L  = 1'b1;
    valid_in = 1'b0;
    data_in  = 32'd0;
    tick();
    checks++;
    if (data_out !== 8'hBC || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: data_out=%h valid_out=%b expected BC/0", data_out, valid_out);
    end
    data_in  = 32'hABCD0001;
    valid_in = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: ready_out=%b expected 1", ready_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      valid_in = 1'b0;
      data_in  = 32'd0;
      #1;
      checks++;
      if (data_out !== exp_b[i] || valid_out !== 1'b1 || ready_out !== (i == 3)) begin
        errors++;
        $display("FAIL single_byte%0d: data_out=%h valid_out=%b ready_out=%b expected %h/1/%b",
                 i, data_out, valid_out, ready_out, exp_b[i], (i == 3));
      end
    end
    tick();
    checks++;
    if (data_out !== 8'hBC || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL single_after: data_out=%h valid_out=%b expected BC/0", data_out, valid_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [8];
    exp_b = '{8'h00, 8'h00, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h57, 8'h98};
    valid_in = 1'b1;
    data_in  = 32'h0000ABCD;
    for (int e = 0; e < 8; e++) begin
      #1;
      checks++;
      if (ready_out !== (e == 0 || e == 4)) begin
        errors++;
        $display("FAIL b2b_ready%0d: ready_out=%b expected %b", e, ready_out, (e == 0 || e == 4));
      end
      tick();
      if (e == 0) data_in = 32'h00015798;
      if (e == 4) valid_in = 1'b0;
      checks++;
      if (data_out !== exp_b[e] || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL b2b_byte%0d: data_out=%h valid_out=%b expected %h/1",
                 e, data_out, valid_out, exp_b[e]);
      end
    end
    tick();
    checks++;
    if (data_out !== 8'hBC || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_after: data_out=%h valid_out=%b expected BC/0", data_out, valid_out);
    end
  endtask

  task automatic test_active_drop();
    logic [7:0] exp_b [4];
    logic [7:0] exp_n [4];
    exp_b = '{8'h00, 8'h00, 8'hEF, 8'hAB};
    exp_n = '{8'h11, 8'h22, 8'h33, 8'h44};
    active   = 1'b1;
    valid_in = 1'b1;
    data_in  = 32'h0000EFAB;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        active  = 1'b0;
        data_in = 32'h11223344;
      end
      checks++;
      if (data_out !== exp_b[i] || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL drop_byte%0d: data_out=%h valid_out=%b expected %h/1",
                 i, data_out, valid_out, exp_b[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (data_out !== 8'hBC || valid_out !== 1'b0 || ready_out !== 1'b0) begin
        errors++;
        $display("FAIL drop_idle%0d: data_out=%h valid_out=%b ready_out=%b expected BC/0/0",
                 i, data_out, valid_out, ready_out);
      end
    end
    active = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL drop_resume_ready: ready_out=%b expected 1", ready_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      valid_in = 1'b0;
      checks++;
      if (data_out !== exp_n[i] || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL drop_resume%0d: data_out=%h valid_out=%b expected %h/1",
                 i, data_out, valid_out, exp_n[i]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    valid_in = 1'b1;
    data_in  = 32'h12345678;
    tick();
    valid_in = 1'b0;
    checks++;
    if (data_out !== 8'h12 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL rmid_first: data_out=%h valid_out=%b expected 12/1", data_out, valid_out);
    end
    reset_L = 1'b0;
    #1;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL rmid_ready: ready_out=%b expected 0", ready_out);
    end
    tick();
    reset_L = 1'b1;
    checks++;
    if (data_out !== 8'h00 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rmid_reset: data_out=%h valid_out=%b expected 00/0", data_out, valid_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (data_out !== 8'hBC || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL rmid_after%0d: data_out=%h valid_out=%b expected BC/0", i, data_out, valid_out);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_b [4];
    exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    valid_in = 1'b1;
    data_in  = 32'hA5A5A5A5;
    tick();
    data_in = 32'hDEADBEEF;
    for (int i = 1; i < 4; i++) begin
      #1;
      checks++;
      if (ready_out !== 1'b0 || data_out !== 8'hA5) begin
        errors++;
        $display("FAIL stall_hold%0d: ready_out=%b data_out=%h expected 0/A5", i, ready_out, data_out);
      end
      tick();
    end
    #1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL stall_ready: ready_out=%b expected 1", ready_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      valid_in = 1'b0;
      checks++;
      if (data_out !== exp_b[i] || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL stall_byte%0d: data_out=%h valid_out=%b expected %h/1",
                 i, data_out, valid_out, exp_b[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (data_out !== 8'hBC || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL stall_after%0d: data_out=%h valid_out=%b expected BC/0", i, data_out, valid_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_active_drop();
    test_reset_mid();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_32_8.md
CONV_32_8 -- requirements
Module: conv_32_8

Interface
REQ-001 The block SHALL expose clk_4f, input, 1 bit: single clock, rising-edge active, running at 4x the word rate of the upstream Flops/Recirculation stage.
REQ-002 The block SHALL expose reset_L, input, 1 bit: reset, synchronous and active-low, sampled on the rising edge of clk_4f.
REQ-003 The block SHALL expose active, input, 1 bit: link-active qualifier from upstream; when low, no new word is accepted.
REQ-004 The block SHALL expose data_in, input, 32 bits: word from the Recirculation stage output.
REQ-005 The block SHALL expose valid_in, input, 1 bit: data_in is valid.
REQ-006 The block SHALL expose ready_out, output, 1 bit: the block accepts data_in on this edge.
REQ-007 The block SHALL expose data_out, output, 8 bits: serialized byte, registered.
REQ-008 The block SHALL expose valid_out, output, 1 bit: data_out carries payload, registered.
REQ-009 The block SHALL define parameter IDLE_SYM, default 8'hBC: byte driven on data_out when no payload is sent.

Function
REQ-010 The block SHALL implement two states: IDLE (no word held) and SEND (word held, byte index cnt in {1,2,3}).
REQ-011 ready_out SHALL equal reset_L AND active AND (state==IDLE), combinational, with no dependence on valid_in.
REQ-012 A word SHALL be accepted on any rising edge where valid_in==1 and ready_out==1; data_in is sampled only on such edges.
REQ-013 On the accept edge, the block SHALL do all of the following: hold_reg <= data_in; data_out <= data_in[31:24]; valid_out <= 1; cnt <= 1; state <= SEND.
REQ-014 In SEND, each edge SHALL emit the next byte, MSB first: cnt=1 -> hold_reg[23:16]; cnt=2 -> [15:8]; cnt=3 -> [7:0]. valid_out <= 1 and cnt increments.
REQ-015 The edge that emits cnt=3 SHALL return state to IDLE.
REQ-016 Latency SHALL be zero added cycles: the first byte is visible after the accept edge, and the last byte after accept+3.
REQ-017 Throughput SHALL be one word per 4 cycles, back-to-back with no gap: the next accept occurs on edge accept+4 and emits its MSB.
REQ-018 In IDLE with no accept, the block SHALL drive data_out <= IDLE_SYM and valid_out <= 0.
REQ-019 If active falls during SEND, the block SHALL finish the held word (all 4 bytes), then stay in IDLE emitting IDLE_SYM until active==1.
REQ-020 If valid_in==1 while ready_out==0, no sampling SHALL occur; upstream holds data_in and valid_in. The block SHALL drop no word and duplicate no word.
REQ-021 Word bytes SHALL never interleave: hold_reg SHALL not be written while in SEND.
REQ-022 Byte order SHALL be fixed big-endian; no byte reordering, padding or CRC is inserted.

Reset
REQ-023 On a rising edge with reset_L==0, the block SHALL do all of the following: state <= IDLE; cnt <= 0; hold_reg <= 0; data_out <= 8'h00; valid_out <= 0.
REQ-024 ready_out SHALL be 0 whenever reset_L==0.
REQ-025 Reset asserted mid-word SHALL abort the word immediately, with no remaining bytes emitted.
REQ-026 On the first edge after reset_L returns to 1, the block SHALL be in IDLE and SHALL accept a word if valid_in, active and ready_out are all high.

Verification
REQ-027 Single word: reset 2 cycles, active=1, then valid_in=1 with data_in=32'hABCD0001 for one accept -> data_out sequence AB, CD, 00, 01 with valid_out=1 for 4 cycles, then BC with valid_out=0.
REQ-028 Back-to-back: valid_in held high with words 32'h0000ABCD then 32'h00015798 -> 00, 00, AB, CD, 00, 01, 57, 98 contiguous; ready_out high exactly on edges 0 and 4.
REQ-029 Active drop: active=0 one cycle after accepting 32'h0000EFAB -> all 4 bytes still emitted; ready_out stays 0 and data_out=BC until active=1.
REQ-030 Reset mid-word: reset_L=0 on edge accept+1 for 32'h12345678 -> data_out=00 and valid_out=0 on that edge; no 56 or 78 is ever emitted.
REQ-031 Stall hold: valid_in=1 with 32'hDEADBEEF asserted during SEND of a prior word -> the word is accepted only on the next IDLE edge and emitted once as DE, AD, BE, EF.
